// File: rtl/score_scheduler.sv
// Scoreboard sequencer: two saturating scores, shared BCD converter passes, 4-digit scan.
// Define LEADING_ZERO_BLANK_EN to blank zero tens digits on the display.
module score_scheduler #(
   parameter int REFRESH_DIV = 50000,
   parameter int MAX_SCORE   = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_a,
   input  logic       inc_b,
   input  logic       dec_a,
   input  logic       dec_b,
   input  logic       clr,
   output logic [4:0] conv_x,
   input  logic [3:0] conv_n2,
   input  logic [3:0] conv_n1,
   output logic [4:0] score_a,
   output logic [4:0] score_b,
   output logic [1:0] winner,
   output logic [3:0] digit_sel,
   output logic [3:0] digit_bcd
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [4:0] MAX5 = 5'(MAX_SCORE);

   typedef enum logic [1:0] {IDLE, CAP_A, CAP_B} state_t;

   state_t           r_state, w_nextState;
   logic [4:0]       r_scoreA, r_scoreB, r_convX;
   logic [4:0]       w_nextA, w_nextB;
   logic [1:0]       r_winner, w_nextWinner;
   logic             r_dirty, w_changed;
   logic [5:0]       r_cacheA, r_cacheB;
   logic [1:0]       r_slot;
   logic [CNT_W-1:0] r_refreshCnt;
   logic [3:0]       r_digitSel, r_digitBcd, w_sel, w_bcd;
   logic             w_unusedN2;

   // Upper tens bits are always zero for a 0..31 input.
   assign w_unusedN2 = &conv_n2[3:2];

   always_comb begin
      w_nextA = r_scoreA;
      w_nextB = r_scoreB;
      if (clr) begin
         w_nextA = '0;
         w_nextB = '0;
      end else if (r_winner == 2'b00) begin
         if (inc_a && !dec_a && r_scoreA != MAX5)
            w_nextA = r_scoreA + 5'd1;
         else if (dec_a && !inc_a && r_scoreA != 5'd0)
            w_nextA = r_scoreA - 5'd1;
         if (inc_b && !dec_b && r_scoreB != MAX5)
            w_nextB = r_scoreB + 5'd1;
         else if (dec_b && !inc_b && r_scoreB != 5'd0)
            w_nextB = r_scoreB - 5'd1;
      end
   end

   always_comb begin
      w_nextWinner = r_winner;
      if (clr)
         w_nextWinner = 2'b00;
      else if (r_winner == 2'b00 && w_nextA == MAX5)
         w_nextWinner = 2'b01;
      else if (r_winner == 2'b00 && w_nextB == MAX5)
         w_nextWinner = 2'b10;
   end

   assign w_changed = clr || (w_nextA != r_scoreA) || (w_nextB != r_scoreB);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scoreA <= '0;
         r_scoreB <= '0;
         r_winner <= '0;
      end else begin
         r_scoreA <= w_nextA;
         r_scoreB <= w_nextB;
         r_winner <= w_nextWinner;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (r_dirty) w_nextState = CAP_A;
         CAP_A:   w_nextState = CAP_B;
         CAP_B:   w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // A score change always wins over the IDLE clear, forcing another pass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dirty  <= 1'b1;
         r_convX  <= '0;
         r_cacheA <= '0;
         r_cacheB <= '0;
      end else begin
         if (w_changed)
            r_dirty <= 1'b1;
         else if (r_state == IDLE && r_dirty)
            r_dirty <= 1'b0;
         case (r_state)
            IDLE: if (r_dirty) r_convX <= r_scoreA;
            CAP_A: begin
               r_cacheA <= {conv_n2[1:0], conv_n1};
               r_convX  <= r_scoreB;
            end
            CAP_B: r_cacheB <= {conv_n2[1:0], conv_n1};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_refreshCnt <= '0;
         r_slot       <= '0;
      end else if (r_refreshCnt == CNT_W'(REFRESH_DIV - 1)) begin
         r_refreshCnt <= '0;
         r_slot       <= r_slot + 2'd1;
      end else begin
         r_refreshCnt <= r_refreshCnt + 1'b1;
      end
   end

   always_comb begin
      w_sel = 4'b0000;
      w_bcd = 4'd0;
      case (r_slot)
         2'd0: begin w_sel = 4'b1000; w_bcd = {2'b00, r_cacheA[5:4]}; end
         2'd1: begin w_sel = 4'b0100; w_bcd = r_cacheA[3:0]; end
         2'd2: begin w_sel = 4'b0010; w_bcd = {2'b00, r_cacheB[5:4]}; end
         default: begin w_sel = 4'b0001; w_bcd = r_cacheB[3:0]; end
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      if ((r_slot == 2'd0 && r_cacheA[5:4] == 2'b00) ||
          (r_slot == 2'd2 && r_cacheB[5:4] == 2'b00)) begin
         w_sel = 4'b0000;
         w_bcd = 4'd0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_digitSel <= '0;
         r_digitBcd <= '0;
      end else begin
         r_digitSel <= w_sel;
         r_digitBcd <= w_bcd;
      end
   end

   assign conv_x    = r_convX;
   assign score_a   = r_scoreA;
   assign score_b   = r_scoreB;
   assign winner    = r_winner;
   assign digit_sel = r_digitSel;
   assign digit_bcd = r_digitBcd;

endmodule

// File: tb/tb_score_scheduler.sv
// Directed self-checking bench for score_scheduler with a behavioural BCD converter.
module tb_score_scheduler;

   localparam int DIV = 4;

   logic       clk, rst;
   logic       incA, incB, decA, decB, clrIn;
   logic [4:0] convX, scoreA, scoreB;
   logic [3:0] convN2, convN1, digitSel, digitBcd;
   logic [1:0] winner;
   int         vectors = 0;
   int         miscompares = 0;
   int         edgeCount;

   score_scheduler #(.REFRESH_DIV(DIV), .MAX_SCORE(21)) dut (
      .clk(clk), .rst(rst),
      .inc_a(incA), .inc_b(incB), .dec_a(decA), .dec_b(decB), .clr(clrIn),
      .conv_x(convX), .conv_n2(convN2), .conv_n1(convN1),
      .score_a(scoreA), .score_b(scoreB), .winner(winner),
      .digit_sel(digitSel), .digit_bcd(digitBcd)
   );

   // Shared converter modelled as pure combinational binary-to-BCD.
   assign convN2 = 4'(convX / 5'd10);
   assign convN1 = 4'(convX % 5'd10);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts active edges since reset release to locate the scan slot.
   always @(posedge clk or posedge rst) begin
      if (rst) edgeCount <= 0;
      else     edgeCount <= edgeCount + 1;
   end

   function automatic logic [3:0] expSel(int e, int a, int b);
      int slot;
      if (e == 0) return 4'b0000;
      slot = ((e - 1) / DIV) % 4;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot == 0 && a / 10 == 0) return 4'b0000;
      if (slot == 2 && b / 10 == 0) return 4'b0000;
`endif
      return 4'b1000 >> slot;
   endfunction

   function automatic logic [3:0] expBcd(int e, int a, int b);
      int slot;
      if (e == 0) return 4'd0;
      slot = ((e - 1) / DIV) % 4;
      case (slot)
         0: return 4'(a / 10);
         1: return 4'(a % 10);
         2: return 4'(b / 10);
         default: return 4'(b % 10);
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Drives one single-cycle pulse starting at a falling edge; returns at the next falling edge.
   task automatic applyStimulus(input logic ia, input logic da, input logic ib, input logic db, input logic c);
      incA = ia; decA = da; incB = ib; decB = db; clrIn = c;
      @(negedge clk);
      incA = 0; decA = 0; incB = 0; decB = 0; clrIn = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkDisplay(input int a, input int b);
      for (int i = 0; i < 4 * DIV; i++) begin
         @(negedge clk);
         checkOutput("digit_sel", 32'(digitSel), 32'(expSel(edgeCount, a, b)));
         checkOutput("digit_bcd", 32'(digitBcd), 32'(expBcd(edgeCount, a, b)));
      end
   endtask

   initial begin
      rst = 1; incA = 0; decA = 0; incB = 0; decB = 0; clrIn = 0;
      #12;
      checkOutput("rst_score_a", 32'(scoreA), 0);
      checkOutput("rst_conv_x", 32'(convX), 0);
      checkOutput("rst_winner", 32'(winner), 0);
      checkOutput("rst_digit_sel", 32'(digitSel), 0);
      @(negedge clk);
      rst = 0;
      checkDisplay(0, 0);

      for (int i = 0; i < 13; i++) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("inc13_score_a", 32'(scoreA), 13);
      idle(6);
      checkOutput("settled_conv_x", 32'(convX), 0);
      checkDisplay(13, 0);

      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("incb_score_b", 32'(scoreB), 1);
      checkOutput("lat_k_conv_x", 32'(convX), 0);
      idle(1);
      checkOutput("lat_k1_conv_x", 32'(convX), 13);
      idle(1);
      checkOutput("lat_k2_conv_x", 32'(convX), 1);
      idle(4);
      checkDisplay(13, 1);

      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("decb_score_b", 32'(scoreB), 0);
      idle(6);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("decb_sat_score_b", 32'(scoreB), 0);
      idle(1);
      checkOutput("decb_nopass_conv_x", 32'(convX), 0);

      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 0);
      checkOutput("dec8_score_a", 32'(scoreA), 5);
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("incdec_score_a", 32'(scoreA), 5);

      for (int i = 0; i < 15; i++) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("a20_score_a", 32'(scoreA), 20);
      checkOutput("a20_winner", 32'(winner), 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("a21_score_a", 32'(scoreA), 21);
      checkOutput("a21_winner", 32'(winner), 1);
      applyStimulus(0, 1, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("won_score_a", 32'(scoreA), 21);
      checkOutput("won_score_b", 32'(scoreB), 0);
      checkOutput("won_winner", 32'(winner), 1);
      idle(6);
      checkDisplay(21, 0);

      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("clr_score_a", 32'(scoreA), 0);
      checkOutput("clr_winner", 32'(winner), 0);
      idle(6);
      checkDisplay(0, 0);
      applyStimulus(1, 0, 1, 0, 1);
      checkOutput("clrinc_score_a", 32'(scoreA), 0);
      checkOutput("clrinc_score_b", 32'(scoreB), 0);

      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      idle(6);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("capa_score_a", 32'(scoreA), 3);
      idle(1);
      checkOutput("capa_k1_conv_x", 32'(convX), 3);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("capa_score_b", 32'(scoreB), 1);
      checkOutput("capa_k2_conv_x", 32'(convX), 0);
      idle(1);
      checkOutput("capa_k3_conv_x", 32'(convX), 0);
      idle(1);
      checkOutput("rerun_k4_conv_x", 32'(convX), 3);
      idle(1);
      checkOutput("rerun_k5_conv_x", 32'(convX), 1);
      idle(4);
      checkDisplay(3, 1);

      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 0);
      checkOutput("b7_score_b", 32'(scoreB), 7);
      idle(6);
      checkDisplay(3, 7);

      applyStimulus(1, 0, 0, 0, 0);
      idle(1);
      checkOutput("midpass_conv_x", 32'(convX), 4);
      #2 rst = 1;
      #1;
      checkOutput("arst_score_a", 32'(scoreA), 0);
      checkOutput("arst_score_b", 32'(scoreB), 0);
      checkOutput("arst_conv_x", 32'(convX), 0);
      checkOutput("arst_digit_sel", 32'(digitSel), 0);
      checkOutput("arst_digit_bcd", 32'(digitBcd), 0);
      @(negedge clk);
      rst = 0;
      checkDisplay(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/score_scheduler.md
# score_scheduler

Sequencing controller for the scoreboard: holds the two player scores (0–31), applies increment/decrement requests, and time-shares one external 5-bit binary-to-BCD converter between the two scores. The resulting four BCD digits are cached and scanned onto a multiplexed 4-digit display. It sits between the debounced button pulses and the shared converter/7-segment decoder.

## Interface
- REFRESH_DIV, 50000 — clock cycles each display digit slot is held; legal range 2..2^20.
- MAX_SCORE, 21 — winning score; legal range 1..31.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- inc_a, inc_b  in  1  single-cycle increment pulses for player A/B, synchronous to clk
- dec_a, dec_b  in  1  single-cycle decrement pulses for player A/B
- clr  in  1  synchronous clear of scores and winner
- conv_x  out  5  binary value presented to the shared converter (registered)
- conv_n2, conv_n1  in  4 each  tens/ones BCD returned by the converter (combinational from conv_x)
- score_a, score_b  out  5 each  current scores (registered)
- winner  out  2  2'b01 A won, 2'b10 B won, 2'b00 none
- digit_sel  out  4  one-hot active-high digit enable, bit 3 = A tens … bit 0 = B ones
- digit_bcd  out  4  BCD value for the enabled digit

## Operation
- Reset: score_a, score_b, winner, conv_x, digit_sel, digit_bcd, all caches = 0; FSM = IDLE; slot = 0; refresh counter = 0; dirty = 1.
- Score update, per player, priority order: clr (both scores and winner to 0, dirty=1) > winner != 0 (all inc/dec ignored) > inc and dec together (no change) > inc (saturate at MAX_SCORE) > dec (saturate at 0).
- Any actual score change sets dirty. Reaching MAX_SCORE sets winner in the same edge; if both players reach MAX_SCORE on the same edge, winner = 2'b01 (A priority).
- Converter FSM, states IDLE, CAP_A, CAP_B:
  - IDLE: if dirty, then conv_x <= score_a, dirty <= 0, go CAP_A.
  - CAP_A: cache_a <= {conv_n2, conv_n1}, conv_x <= score_b, go CAP_B.
  - CAP_B: cache_b <= {conv_n2, conv_n1}, go IDLE.
  - A score change during CAP_A/CAP_B re-sets dirty, so a full pass is rerun; the current pass completes unchanged.
- Display scan: refresh counter counts 0..REFRESH_DIV-1; on wrap, slot advances 0→1→2→3→0. Registered outputs per slot: 0 → digit_sel 4'b1000, cache_a tens; 1 → 4'b0100, cache_a ones; 2 → 4'b0010, cache_b tens; 3 → 4'b0001, cache_b ones.
- conv_n2[3:2] are ignored (always 0 for legal inputs).

## Timing
- Score change registered at edge k; score_a/score_b/winner valid after k.
- Earliest pass: conv_x = score_a after k+1, cache_a after k+2, cache_b after k+3; digit_bcd reflects the new cache on the first clock after the cache update while the matching slot is active.
- After reset release: first pass completes at edge 3; digit_sel = 4'b1000 from edge 1.
- Each slot lasts exactly REFRESH_DIV cycles; full frame = 4·REFRESH_DIV.
- Async rst mid-pass abandons the pass; all state returns to reset values immediately.
- clr and inc/dec in the same cycle: clr wins, scores = 0.

## Configuration
- LEADING_ZERO_BLANK_EN defined: in slots 0 and 2, if the cached tens digit is 0, digit_sel = 4'b0000 (digit blanked) and digit_bcd = 0; ones digits are always shown.
- Not defined: tens digit 0 is displayed as 0 with the normal one-hot digit_sel.

## Test plan
- Reset, no input, REFRESH_DIV=4 → digit_sel cycles 1000,0100,0010,0001 every 4 clocks; digit_bcd = 0; conv_x = 0; winner = 0.
- Pulse inc_a 13 times → score_a = 13; 3 clocks after the last pulse cache_a = {1,3}; slot 0 shows 1, slot 1 shows 3.
- dec_b at score_b = 0 → stays 0, no pass started; inc_a and dec_a in the same cycle at score_a = 5 → stays 5.
- Drive score_a to 20, then inc_a → score_a = 21, winner = 01; further inc_b/dec_a ignored; clr → scores 0, winner 00, caches 0 after 3 clocks.
- inc_b during CAP_A → the pass completes, then a second pass runs; cache_b ends equal to the BCD of the new score_b.
- With LEADING_ZERO_BLANK_EN and score_b = 7 → slot 2 digit_sel = 0000; slot 3 = 0001 with digit_bcd 7. Without the macro → slot 2 = 0010 with digit_bcd 0.
